// File: rtl/e_controller_pkg.sv
// e_controller_pkg: shared MIPS32 pipeline definitions (opcodes, functs, ALU encodings, hazard constants, decode flags)
package e_controller_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_LUI  = 2'b11;
  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [4:0] REG_RA   = 5'd31;
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
  } instr_flags_t;
endpackage

// File: rtl/e_controller_if.sv
// e_controller_if: D/E boundary inputs (clr, instr) and E-stage decode outputs
//   master: pipeline/hazard side (drives clr, instr; reads decode)
//   slave : e_controller side (reads clr, instr; drives instr_E and decode)
interface e_controller_if;
  logic        clr;
  logic [31:0] instr;
  logic [31:0] instr_E;
  logic [1:0]  Tuse_rs;
  logic [1:0]  Tuse_rt;
  logic [1:0]  Tnew;
  logic [4:0]  A3;
  logic        alu_src;
  logic [1:0]  alu_op;
  modport master (output clr, instr, input instr_E, Tuse_rs, Tuse_rt, Tnew, A3, alu_src, alu_op);
  modport slave (input clr, instr, output instr_E, Tuse_rs, Tuse_rt, Tnew, A3, alu_src, alu_op);
endinterface

// File: rtl/e_controller_instr_decode.sv
// instr_decode: one-hot instruction flags from opcode/funct
//   opcode_i [5:0], funct_i [5:0] -> flags_o (all zero for unsupported encodings)
module instr_decode
  import e_controller_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  output instr_flags_t flags_o
);
  logic rtype;
  assign rtype = opcode_i == OP_RTYPE;
  always_comb begin
    flags_o      = '0;
    flags_o.addu = rtype && funct_i == FN_ADDU;
    flags_o.subu = rtype && funct_i == FN_SUBU;
    flags_o.jr   = rtype && funct_i == FN_JR;
    flags_o.ori  = opcode_i == OP_ORI;
    flags_o.lw   = opcode_i == OP_LW;
    flags_o.sw   = opcode_i == OP_SW;
    flags_o.beq  = opcode_i == OP_BEQ;
    flags_o.lui  = opcode_i == OP_LUI;
    flags_o.j    = opcode_i == OP_J;
    flags_o.jal  = opcode_i == OP_JAL;
  end
endmodule

// File: rtl/e_controller.sv
// e_controller: E-stage instruction register plus ALU/write-back/hazard-timing decode
//   clk, reset (async, active-high), bus (slave): clr, instr in; instr_E, Tuse_rs, Tuse_rt, Tnew, A3, alu_src, alu_op out
module e_controller
  import e_controller_pkg::*;
(
  input logic          clk,
  input logic          reset,
  e_controller_if.slave bus
);
  logic [31:0]  instr_q;
  logic [31:0]  instr_d;
  instr_flags_t f;
  assign instr_d = bus.clr ? '0 : bus.instr;
  always_ff @(posedge clk or posedge reset)
    if (reset) instr_q <= '0;
    else instr_q <= instr_d;
  instr_decode u_dec (
    .opcode_i(instr_q[31:26]),
    .funct_i (instr_q[5:0]),
    .flags_o (f)
  );
  assign bus.instr_E = instr_q;
  // jal's link value exists before E, so it writes $ra with Tnew 0
  always_comb begin
    bus.Tuse_rs = (f.addu | f.subu | f.ori | f.lw | f.sw) ? 2'd1 : (f.jr | f.beq) ? 2'd0 : TUSE_NONE;
    bus.Tuse_rt = (f.addu | f.subu) ? 2'd1 : f.sw ? 2'd2 : f.beq ? 2'd0 : TUSE_NONE;
    bus.Tnew    = f.lw ? 2'd2 : (f.addu | f.subu | f.ori | f.lui) ? 2'd1 : 2'd0;
    bus.A3      = (f.addu | f.subu) ? instr_q[15:11] : (f.ori | f.lw | f.lui) ? instr_q[20:16] : f.jal ? REG_RA : 5'd0;
    bus.alu_src = f.ori | f.lw | f.sw | f.lui;
    bus.alu_op  = (f.subu | f.beq) ? ALU_SUB : f.ori ? ALU_OR : f.lui ? ALU_LUI : ALU_ADD;
  end
endmodule

// File: tb/tb_e_controller.sv
// tb_e_controller: directed literal checks plus randomized stimulus against a table-driven reference model
module tb_e_controller;
  typedef struct packed {
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] tnew;
    logic [4:0] a3;
    logic       src;
    logic [1:0] op;
  } dec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_e = '0;
  e_controller_if bus ();
  e_controller dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic dec_t ref_dec(logic [31:0] i);
    dec_t d;
    d = '{2'd3, 2'd3, 2'd0, 5'd0, 1'b0, 2'b00};
    case (i[31:26])
      6'h00: case (i[5:0])
        6'h21: d = '{2'd1, 2'd1, 2'd1, i[15:11], 1'b0, 2'b00};
        6'h23: d = '{2'd1, 2'd1, 2'd1, i[15:11], 1'b0, 2'b01};
        6'h08: d = '{2'd0, 2'd3, 2'd0, 5'd0, 1'b0, 2'b00};
        default: ;
      endcase
      6'h0D: d = '{2'd1, 2'd3, 2'd1, i[20:16], 1'b1, 2'b10};
      6'h23: d = '{2'd1, 2'd3, 2'd2, i[20:16], 1'b1, 2'b00};
      6'h2B: d = '{2'd1, 2'd2, 2'd0, 5'd0, 1'b1, 2'b00};
      6'h04: d = '{2'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'b01};
      6'h0F: d = '{2'd3, 2'd3, 2'd1, i[20:16], 1'b1, 2'b11};
      6'h02: d = '{2'd3, 2'd3, 2'd0, 5'd0, 1'b0, 2'b00};
      6'h03: d = '{2'd3, 2'd3, 2'd0, 5'd31, 1'b0, 2'b00};
      default: ;
    endcase
    return d;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_model(input string tag);
    dec_t act;
    act = '{bus.Tuse_rs, bus.Tuse_rt, bus.Tnew, bus.A3, bus.alu_src, bus.alu_op};
    chk({tag, "_instr_E"}, bus.instr_E, exp_e);
    chk({tag, "_decode"}, 32'(act), 32'(ref_dec(exp_e)));
  endtask
  task automatic tick(input logic [31:0] ins, input logic c);
    bus.instr = ins;
    bus.clr = c;
    @(posedge clk);
    if (!reset) exp_e = c ? '0 : ins;
    @(negedge clk);
    check_model("model");
  endtask
  task automatic lit(input string n, input int rs, input int rt, input int tn, input int a3, input int src, input int op);
    chk({n, "_Tuse_rs"}, 32'(bus.Tuse_rs), 32'(rs));
    chk({n, "_Tuse_rt"}, 32'(bus.Tuse_rt), 32'(rt));
    chk({n, "_Tnew"}, 32'(bus.Tnew), 32'(tn));
    chk({n, "_A3"}, 32'(bus.A3), 32'(a3));
    chk({n, "_alu_src"}, 32'(bus.alu_src), 32'(src));
    chk({n, "_alu_op"}, 32'(bus.alu_op), 32'(op));
  endtask
  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    rs = 5'($urandom);
    rt = 5'($urandom);
    rd = 5'($urandom);
    imm = 16'($urandom);
    case ($urandom_range(0, 12))
      0: return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      1: return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      2: return {6'h00, rs, 15'd0, 6'h08};
      3: return {6'h0D, rs, rt, imm};
      4: return {6'h23, rs, rt, imm};
      5: return {6'h2B, rs, rt, imm};
      6: return {6'h04, rs, rt, imm};
      7: return {6'h0F, 5'd0, rt, imm};
      8: return {6'h02, 26'($urandom)};
      9: return {6'h03, 26'($urandom)};
      10: return {6'h00, rs, rt, rd, 5'($urandom), 6'($urandom)};
      11: return 32'd0;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    bus.instr = 32'h00851021;
    bus.clr = 1'b0;
    #3;
    lit("reset", 3, 3, 0, 0, 0, 0);
    chk("reset_instr_E", bus.instr_E, 32'h0);
    repeat (2) @(negedge clk);
    lit("reset_hold", 3, 3, 0, 0, 0, 0);
    reset = 1'b0;
    tick(32'h00851821, 1'b0);
    chk("addu_instr_E", bus.instr_E, 32'h00851821);
    lit("addu", 1, 1, 1, 3, 0, 0);
    tick(32'h8D280004, 1'b0);
    lit("lw", 1, 3, 2, 8, 1, 0);
    tick(32'hAD280004, 1'b0);
    lit("sw", 1, 2, 0, 0, 1, 0);
    tick(32'h340200FF, 1'b0);
    lit("ori", 1, 3, 1, 2, 1, 2);
    tick(32'h3C071234, 1'b0);
    lit("lui", 3, 3, 1, 7, 1, 3);
    tick(32'h0C000010, 1'b0);
    lit("jal", 3, 3, 0, 31, 0, 0);
    tick(32'h10850003, 1'b0);
    lit("beq", 0, 0, 0, 0, 0, 1);
    tick(32'h00851821, 1'b1);
    chk("clr_instr_E", bus.instr_E, 32'h0);
    lit("clr", 3, 3, 0, 0, 0, 0);
    tick(32'hFC000000, 1'b0);
    lit("undef", 3, 3, 0, 0, 0, 0);
    tick(32'h00851821, 1'b0);
    #2 reset = 1'b1;
    exp_e = '0;
    #1 check_model("async");
    lit("async", 3, 3, 0, 0, 0, 0);
    tick(32'h00851821, 1'b0);
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b1;
        exp_e = '0;
        #1 check_model("rand_async");
        tick(rand_instr(), 1'b0);
        reset = 1'b0;
      end
      tick(rand_instr(), $urandom_range(0, 7) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
